// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO read-side stream consumer.
package fifo_stream_pkg;

  // Words the prefetch buffer can hold; covers one cycle of RAM read latency.
  localparam int PREFETCH_DEPTH = 2;

  // Defaults kept in step with the generate_memory FIFO instantiations.
  localparam int DEF_M_WIDTH    = 32;
  localparam int DEF_BURST_LEN  = 16;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_prefetch_buf.sv
// Two-entry in-order queue holding words returned by the FIFO until the
// downstream consumer takes them. Callers never push when full or pop when empty.
module stream_prefetch_buf
  import fifo_stream_pkg::*;
#(
  parameter int W = DEF_M_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output occ_t         o_occ,
  output logic [W-1:0] o_head
);

  logic [W-1:0] mem_q [PREFETCH_DEPTH];
  logic         head_q, head_d;
  logic         tail_q, tail_d;
  occ_t         occ_q, occ_d;

  // Pointer and occupancy update; simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (i_push) tail_d = ~tail_q;
    if (i_pop)  head_d = ~head_q;
    case ({i_push, i_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (i_push) mem_q[tail_q] <= i_push_data;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign o_occ  = occ_q;
  assign o_head = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the dual-clock FIFO: issues reads, absorbs the
// one-cycle RAM latency in a prefetch buffer and presents a valid/ready
// stream with packet framing every BURST_LEN beats.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter  int M_WIDTH   = DEF_M_WIDTH,
  parameter  int BURST_LEN = DEF_BURST_LEN,
  localparam int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  output logic               o_fifo_read_enable,
  input  logic [M_WIDTH-1:0] i_fifo_read_data,
  input  logic               i_fifo_read_data_valid,
  input  logic               i_fifo_empty,
  output logic [M_WIDTH-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic [CNT_W-1:0]   o_beat_count,
  output logic               o_busy,
  output logic               o_err_unexpected
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_LEN - 1);

  occ_t             occ;
  logic             pop, push;
  logic [2:0]       level;
  logic             inflight_q;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             err_q, err_d;

  assign o_valid = (occ != 2'd0);
  assign pop     = o_valid && i_ready;
  assign push    = inflight_q && i_fifo_read_data_valid;

  // Slots already claimed after this cycle's pop; a new read is only issued
  // when its returning word is guaranteed a free slot.
  assign level = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign o_fifo_read_enable = !i_rst && i_enable && !i_fifo_empty && (level < 3'd2);

  stream_prefetch_buf #(.W(M_WIDTH)) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (i_fifo_read_data),
    .i_pop       (pop),
    .o_occ       (occ),
    .o_head      (o_data)
  );

  // Beat index advances on every pop and wraps at the packet boundary; the
  // error flag latches data returned without a read in flight.
  always_comb begin
    beat_d = beat_q;
    err_d  = err_q;
    if (pop) beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
    if (!inflight_q && i_fifo_read_data_valid) err_d = 1'b1;
  end

  // Read-in-flight tracking, beat counter and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= o_fifo_read_enable;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign o_last           = o_valid && (beat_q == BEAT_LAST);
  assign o_beat_count     = beat_q;
  assign o_busy           = (occ != 2'd0) || inflight_q;
  assign o_err_unexpected = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small read-latency-1 FIFO model.
module tb_fifo_stream_reader;

  logic        i_clk;
  logic        i_rst;
  logic        i_enable;
  logic        o_fifo_read_enable;
  logic [31:0] i_fifo_read_data;
  logic        i_fifo_read_data_valid;
  logic        i_fifo_empty;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic [3:0]  o_beat_count;
  logic        o_busy;
  logic        o_err_unexpected;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fmem [0:63];
  int          rp = 0;
  int          cnt = 0;
  bit          model_en = 0;

  fifo_stream_reader #(.M_WIDTH(32), .BURST_LEN(16)) dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_enable               (i_enable),
    .o_fifo_read_enable     (o_fifo_read_enable),
    .i_fifo_read_data       (i_fifo_read_data),
    .i_fifo_read_data_valid (i_fifo_read_data_valid),
    .i_fifo_empty           (i_fifo_empty),
    .o_data                 (o_data),
    .o_valid                (o_valid),
    .i_ready                (i_ready),
    .o_last                 (o_last),
    .o_beat_count           (o_beat_count),
    .o_busy                 (o_busy),
    .o_err_unexpected       (o_err_unexpected)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; samples the read enable just
  // before the next edge and, in model mode, returns the word one cycle later.
  task automatic tick();
    logic re_s;
    #4;
    re_s = o_fifo_read_enable;
    @(posedge i_clk);
    #1;
    if (model_en) begin
      i_fifo_read_data_valid = re_s;
      if (re_s) begin
        i_fifo_read_data = fmem[rp];
        rp++;
      end
      i_fifo_empty = (rp >= cnt);
    end
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fmem[i] = base + 32'(i);
    rp = 0;
    cnt = n;
    i_fifo_empty = (n == 0);
  endtask

  initial begin
    int k;
    logic [31:0] exp3 [0:11];

    i_rst = 1'b1;
    i_enable = 1'b0;
    i_fifo_read_data = '0;
    i_fifo_read_data_valid = 1'b0;
    i_fifo_empty = 1'b1;
    i_ready = 1'b0;

    @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_re", 32'(o_fifo_read_enable), 0);
    i_rst = 1'b0;
    tick();

    // Full-rate streaming of 32 words with packet framing.
    load(32'h1, 32);
    model_en = 1;
    i_ready = 1'b1;
    i_enable = 1'b1;
    tick();
    chk("lat_valid_c1", 32'(o_valid), 0);
    tick();
    chk("lat_valid_c2", 32'(o_valid), 1);
    for (int i = 0; i < 32; i++) begin
      chk("strm_valid", 32'(o_valid), 1);
      chk("strm_data", o_data, 32'(i + 1));
      chk("strm_last", 32'(o_last), ((i % 16) == 15) ? 32'd1 : 32'd0);
      tick();
    end
    chk("strm_done_valid", 32'(o_valid), 0);
    chk("strm_done_busy", 32'(o_busy), 0);

    // Downstream stall: buffer fills to two, reads stop, head holds.
    i_ready = 1'b0;
    load(32'h100, 12);
    for (int i = 0; i < 12; i++) exp3[i] = 32'h100 + 32'(i);
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t >= 2) begin
        chk("stall_data", o_data, 32'h100);
        chk("stall_valid", 32'(o_valid), 1);
        chk("stall_re", 32'(o_fifo_read_enable), 0);
      end
    end
    chk("stall_reads", 32'(rp), 2);
    chk("stall_busy", 32'(o_busy), 1);
    i_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      if (o_valid) begin
        chk("drain_data", o_data, exp3[k]);
        k++;
      end
      tick();
    end
    chk("drain_count", 32'(k), 12);
    chk("drain_valid", 32'(o_valid), 0);

    // Read in flight when the FIFO turns out empty: reservation dropped.
    model_en = 0;
    i_fifo_read_data_valid = 1'b0;
    i_fifo_empty = 1'b0;
    #1;
    chk("drop_issue", 32'(o_fifo_read_enable), 1);
    tick();
    i_fifo_empty = 1'b1;
    #1;
    chk("drop_re_empty", 32'(o_fifo_read_enable), 0);
    chk("drop_busy_inflight", 32'(o_busy), 1);
    tick();
    chk("drop_valid", 32'(o_valid), 0);
    chk("drop_busy", 32'(o_busy), 0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("drop_re_idle", 32'(o_fifo_read_enable), 0);
    end
    i_fifo_empty = 1'b0;
    #1;
    chk("drop_reissue", 32'(o_fifo_read_enable), 1);
    tick();
    i_fifo_read_data_valid = 1'b1;
    i_fifo_read_data = 32'hABC;
    i_fifo_empty = 1'b1;
    tick();
    i_fifo_read_data_valid = 1'b0;
    chk("drop_ret_valid", 32'(o_valid), 1);
    chk("drop_ret_data", o_data, 32'hABC);
    chk("drop_err", 32'(o_err_unexpected), 0);
    tick();
    chk("drop_pop_valid", 32'(o_valid), 0);
    chk("drop_beat", 32'(o_beat_count), 13);

    // Enable dropped with one word buffered and one in flight.
    load(32'h200, 4);
    model_en = 1;
    i_ready = 1'b0;
    i_enable = 1'b1;
    tick();
    tick();
    chk("en_valid", 32'(o_valid), 1);
    chk("en_data", o_data, 32'h200);
    i_enable = 1'b0;
    #1;
    chk("en_re_off", 32'(o_fifo_read_enable), 0);
    tick();
    chk("en_re_off2", 32'(o_fifo_read_enable), 0);
    chk("en_head", o_data, 32'h200);
    i_ready = 1'b1;
    tick();
    chk("en_second_valid", 32'(o_valid), 1);
    chk("en_second_data", o_data, 32'h201);
    tick();
    chk("en_drained_valid", 32'(o_valid), 0);
    chk("en_drained_busy", 32'(o_busy), 0);
    chk("en_reads", 32'(rp), 2);
    for (int t = 0; t < 2; t++) begin
      tick();
      chk("en_re_idle", 32'(o_fifo_read_enable), 0);
    end
    chk("en_beat", 32'(o_beat_count), 15);

    // Data returned with no read in flight.
    model_en = 0;
    i_fifo_empty = 1'b1;
    i_fifo_read_data_valid = 1'b1;
    i_fifo_read_data = 32'hDEAD;
    tick();
    i_fifo_read_data_valid = 1'b0;
    chk("unexp_err", 32'(o_err_unexpected), 1);
    chk("unexp_valid", 32'(o_valid), 0);
    chk("unexp_busy", 32'(o_busy), 0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("unexp_sticky", 32'(o_err_unexpected), 1);
    end

    // Asynchronous reset with the buffer full.
    load(32'h300, 4);
    model_en = 1;
    i_ready = 1'b0;
    i_enable = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    chk("pre_rst_valid", 32'(o_valid), 1);
    chk("pre_rst_last", 32'(o_last), 1);
    chk("pre_rst_beat", 32'(o_beat_count), 15);
    chk("pre_rst_data", o_data, 32'h300);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_last", 32'(o_last), 0);
    chk("arst_re", 32'(o_fifo_read_enable), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_err", 32'(o_err_unexpected), 0);
    chk("arst_beat", 32'(o_beat_count), 0);
    chk("arst_data", o_data, 0);
    @(posedge i_clk);
    #1;
    model_en = 0;
    i_fifo_read_data_valid = 1'b0;
    i_rst = 1'b0;
    chk("post_rst_valid", 32'(o_valid), 0);
    chk("post_rst_err", 32'(o_err_unexpected), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the dual-clock FIFO wrapper (generate_memory-style). It sits in the FIFO's read clock domain.
- Drives the FIFO read enable and absorbs the 1-cycle RAM read latency in a 2-entry prefetch buffer.
- Presents the words downstream as a valid/ready stream, marking packet boundaries with o_last every BURST_LEN beats.
- Sustains 1 word/cycle when the FIFO is non-empty and downstream is ready.

Parameters:
- M_WIDTH, 32: data word width; must match the FIFO M_WIDTH.
- BURST_LEN, 16: beats per packet for o_last; must be >= 2.
- CNT_W, $clog2(BURST_LEN): beat counter width (localparam, derived).

Ports:
- i_clk  input  1  FIFO read clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  permits new FIFO reads; buffered words still drain when low.
- o_fifo_read_enable  output  1  to FIFO i_read_enable.
- i_fifo_read_data  input  M_WIDTH  from FIFO o_read_data.
- i_fifo_read_data_valid  input  1  from FIFO o_read_data_valid.
- i_fifo_empty  input  1  from FIFO o_empty.
- o_data  output  M_WIDTH  stream data (buffer head).
- o_valid  output  1  stream valid.
- i_ready  input  1  downstream ready.
- o_last  output  1  final beat of the current BURST_LEN packet.
- o_beat_count  output  CNT_W  index of the current head beat within its packet.
- o_busy  output  1  high when buffer occupancy != 0 or a read is in flight.
- o_err_unexpected  output  1  sticky: read data arrived with no read in flight.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high; all state clears immediately on assertion.
- Reset values:
  - occupancy = 0, inflight = 0, beat = 0.
  - Buffer entries = 0.
  - Outputs: o_valid = 0, o_data = 0, o_last = 0, o_fifo_read_enable = 0, o_busy = 0, o_err_unexpected = 0.
- State:
  - occ[1:0] counts buffered words, 0..2.
  - inflight[0] is o_fifo_read_enable registered: 1 means a read was issued last cycle.
  - Buffer is a 2-entry in-order queue with head and tail pointers.
- Pop: pop = o_valid && i_ready. o_valid = (occ != 0). o_data = head entry. Both are driven from registers only.
- Issue: o_fifo_read_enable = i_enable && !i_fifo_empty && (occ + inflight - pop) < 2.
  - Combinational; this is the only combinational path from i_ready.
  - Guarantees a returned word always has a free slot, so there is no overflow by construction.
- Return:
  - When inflight && i_fifo_read_data_valid, push i_fifo_read_data at the tail one cycle after issue (read latency 1).
  - When inflight && !i_fifo_read_data_valid (the FIFO went empty, registered flag), the reservation is dropped and nothing is pushed.
- Unexpected data: when !inflight && i_fifo_read_data_valid, the data is ignored and o_err_unexpected sets. It clears only on reset.
- Simultaneous push and pop: occ is unchanged. Push with occ == 0 makes the word visible on o_data the next cycle; there is no combinational bypass.
- Beat counter:
  - Increments on pop, wrapping from BURST_LEN-1 to 0.
  - o_last = o_valid && beat == BURST_LEN-1.
  - o_beat_count = beat.
- Throughput: steady state is occ = 1, inflight = 1, pop every cycle, giving 1 word/cycle. First-word latency from i_fifo_empty falling is 2 cycles: issue, then return/push, then o_valid.
- Stall: i_ready low holds o_data and o_valid stable; reads stop once occ + inflight = 2.
- i_enable low mid-stream: no new issues. An in-flight word is still captured, and buffered words drain normally.
- Reset mid-operation: any in-flight FIFO data is discarded. The caller resets the FIFO together with this block.

Decomposition:
- Shared package fifo_stream_pkg:
  - PREFETCH_DEPTH = 2.
  - Typedef occ_t (logic [1:0]).
  - Default M_WIDTH/BURST_LEN constants shared with generate_memory instantiations.
- One sub-module: stream_prefetch_buf, the 2-entry in-order queue with push, pop, occ, head data and async reset. The top block holds the issue logic, inflight, beat counter and error flag.

Test Plan:
1. Reset asserted asynchronously mid-cycle with occ = 2 -> o_valid, o_last, o_fifo_read_enable, o_busy, o_err_unexpected all 0 immediately; o_beat_count = 0.
2. Model FIFO holding 0x1..0x20, i_ready = 1 -> first o_valid 2 cycles after i_enable. Then 32 consecutive beats 0x1..0x20 with no bubbles; o_last on beats 16 and 32 (data 0x10, 0x20).
3. i_ready held low for 10 cycles with FIFO non-empty -> exactly 2 words buffered, o_fifo_read_enable stays 0 after 2 issues, o_data stable. Release -> order preserved, no loss or duplication.
4. FIFO goes empty with a read in flight (data_valid = 0 on return) -> nothing pushed, occ unchanged. Next issue occurs only when i_fifo_empty = 0.
5. i_enable dropped while inflight = 1, occ = 1 -> in-flight word captured, 2 words drain. o_fifo_read_enable stays 0 while i_enable is 0.
6. Pulse i_fifo_read_data_valid = 1 with no prior issue -> word not pushed, o_err_unexpected = 1 and stays set until i_rst.
